// File: rtl/processor_pkg.sv
// Shared processor definitions used by the mult/div sequencer.
// Holds the sequencer FSM state encoding, the R-type ALUop codes that
// select the iterative unit, the $rstatus register index and the
// architectural exception codes written to $rstatus.
package processor_pkg;

    // Sequencer FSM state encoding
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_WB    = 2'd3;

    // R-type ALUop values routed to the iterative mult/div unit
    localparam logic [4:0] ALUOP_MUL = 5'b00110;
    localparam logic [4:0] ALUOP_DIV = 5'b00111;

    // Register that receives exception codes
    localparam int RSTATUS_IDX = 30;

    // Exception codes written to $rstatus
    localparam int EXC_ADD  = 1;
    localparam int EXC_ADDI = 2;
    localparam int EXC_SUB  = 3;
    localparam int EXC_MUL  = 4;
    localparam int EXC_DIV  = 5;

    // Select the exception code for the operation in flight
    function automatic int exc_code_sel(input logic is_div, input int mul_code, input int div_code);
        return is_div ? div_code : mul_code;
    endfunction

endpackage

// File: rtl/md_timeout_counter.sv
// Watchdog counter for the mult/div WAIT state.
// Ports:
//   clock    - system clock, rising edge
//   reset    - asynchronous active-low reset
//   clear    - synchronous clear to zero (takes priority over enable)
//   enable   - increment by one this cycle
//   terminal - high while the count equals TIMEOUT-1
module md_timeout_counter #(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = $clog2(TIMEOUT + 1)
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic terminal
);

    logic [CNT_W-1:0] count_r;

    // Count register: clear has priority, then increment when enabled
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count_r <= {CNT_W{1'b0}};
        end else if (clear) begin
            count_r <= {CNT_W{1'b0}};
        end else if (enable) begin
            count_r <= count_r + CNT_W'(1);
        end else begin
            count_r <= count_r;
        end
    end

    // Terminal-count decode; the sequencer leaves WAIT here, so the count never wraps
    always_comb begin
        terminal = (count_r == CNT_W'(TIMEOUT - 1));
    end

endmodule

// File: rtl/multdiv_sequencer.sv
// Multi-cycle sequencer sharing the iterative mult/div unit with the
// single-cycle datapath. A decoded MUL/DIV freezes PC/IR (stall), the
// operands are latched, the unit is started with a one-cycle pulse, the
// result is awaited under a watchdog and a single regfile writeback is
// produced: the result to rd, or an exception code to $rstatus.
// Ports:
//   clock, reset            - clock and asynchronous active-low reset
//   issue_valid/is_div/rd   - decoded MUL/DIV request, its kind and destination
//   operand_a/operand_b     - regfile read data
//   md_ctrl_mult/div        - one-cycle start pulses to the unit
//   md_operand_a/b          - latched operands, stable from ISSUE through WAIT
//   md_result_rdy/result/exception - unit response
//   stall                   - hold PC/IR and suppress the normal regfile write
//   wb_we/wb_rd/wb_data     - one-cycle writeback
//   busy                    - FSM outside IDLE
module multdiv_sequencer
    import processor_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int TIMEOUT      = 64,
    parameter int RSTATUS_REG  = RSTATUS_IDX,
    parameter int MUL_EXC_CODE = EXC_MUL,
    parameter int DIV_EXC_CODE = EXC_DIV
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  issue_valid,
    input  logic                  issue_is_div,
    input  logic [4:0]            issue_rd,
    input  logic [DATA_WIDTH-1:0] operand_a,
    input  logic [DATA_WIDTH-1:0] operand_b,
    output logic                  md_ctrl_mult,
    output logic                  md_ctrl_div,
    output logic [DATA_WIDTH-1:0] md_operand_a,
    output logic [DATA_WIDTH-1:0] md_operand_b,
    input  logic                  md_result_rdy,
    input  logic [DATA_WIDTH-1:0] md_result,
    input  logic                  md_exception,
    output logic                  stall,
    output logic                  wb_we,
    output logic [4:0]            wb_rd,
    output logic [DATA_WIDTH-1:0] wb_data,
    output logic                  busy
);

    logic [1:0]            state_r;
    logic [DATA_WIDTH-1:0] op_a_r;
    logic [DATA_WIDTH-1:0] op_b_r;
    logic [4:0]            rd_r;
    logic                  is_div_r;
    logic [DATA_WIDTH-1:0] result_r;
    logic                  exc_r;
    logic                  cnt_clear_s;
    logic                  cnt_enable_s;
    logic                  cnt_terminal_s;

    md_timeout_counter #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clock    (clock),
        .reset    (reset),
        .clear    (cnt_clear_s),
        .enable   (cnt_enable_s),
        .terminal (cnt_terminal_s)
    );

    // Watchdog control: cleared while the start pulse is out, counts during WAIT
    always_comb begin
        cnt_clear_s  = (state_r == ST_ISSUE);
        cnt_enable_s = (state_r == ST_WAIT);
    end

    // FSM and operand/result capture
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r  <= ST_IDLE;
            op_a_r   <= {DATA_WIDTH{1'b0}};
            op_b_r   <= {DATA_WIDTH{1'b0}};
            rd_r     <= 5'd0;
            is_div_r <= 1'b0;
            result_r <= {DATA_WIDTH{1'b0}};
            exc_r    <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (issue_valid) begin
                        op_a_r   <= operand_a;
                        op_b_r   <= operand_b;
                        rd_r     <= issue_rd;
                        is_div_r <= issue_is_div;
                        state_r  <= ST_ISSUE;
                    end else begin
                        state_r  <= ST_IDLE;
                    end
                end
                ST_ISSUE: begin
                    state_r <= ST_WAIT;
                end
                ST_WAIT: begin
                    // A ready in the terminal cycle still delivers the real result
                    if (md_result_rdy) begin
                        result_r <= md_result;
                        exc_r    <= md_exception;
                        state_r  <= ST_WB;
                    end else if (cnt_terminal_s) begin
                        result_r <= {DATA_WIDTH{1'b0}};
                        exc_r    <= 1'b1;
                        state_r  <= ST_WB;
                    end else begin
                        state_r  <= ST_WAIT;
                    end
                end
                ST_WB: begin
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // Output decode; stall in IDLE follows issue_valid but is forced low during reset
    always_comb begin
        stall        = 1'b0;
        md_ctrl_mult = 1'b0;
        md_ctrl_div  = 1'b0;
        wb_we        = 1'b0;
        wb_rd        = 5'd0;
        wb_data      = {DATA_WIDTH{1'b0}};
        busy         = (state_r != ST_IDLE);
        md_operand_a = op_a_r;
        md_operand_b = op_b_r;
        case (state_r)
            ST_IDLE: begin
                stall = issue_valid & reset;
            end
            ST_ISSUE: begin
                stall        = 1'b1;
                md_ctrl_div  = is_div_r;
                md_ctrl_mult = ~is_div_r;
            end
            ST_WAIT: begin
                stall = 1'b1;
            end
            ST_WB: begin
                stall   = 1'b0;
                wb_we   = exc_r | (rd_r != 5'd0);
                wb_rd   = exc_r ? 5'(RSTATUS_REG) : rd_r;
                wb_data = exc_r ? DATA_WIDTH'(exc_code_sel(is_div_r, MUL_EXC_CODE, DIV_EXC_CODE))
                                : result_r;
            end
            default: begin
                stall = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_multdiv_sequencer.sv
module tb_multdiv_sequencer;

    localparam int DW = 32;
    localparam int TO = 64;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          issue_valid = 1'b0;
    logic          issue_is_div = 1'b0;
    logic [4:0]    issue_rd = 5'd0;
    logic [DW-1:0] operand_a = 32'd0;
    logic [DW-1:0] operand_b = 32'd0;
    logic          md_ctrl_mult;
    logic          md_ctrl_div;
    logic [DW-1:0] md_operand_a;
    logic [DW-1:0] md_operand_b;
    logic          md_result_rdy = 1'b0;
    logic [DW-1:0] md_result = 32'd0;
    logic          md_exception = 1'b0;
    logic          stall;
    logic          wb_we;
    logic [4:0]    wb_rd;
    logic [DW-1:0] wb_data;
    logic          busy;

    int checks = 0;
    int errors = 0;

    multdiv_sequencer #(.DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
        .clock         (clock),
        .reset         (reset),
        .issue_valid   (issue_valid),
        .issue_is_div  (issue_is_div),
        .issue_rd      (issue_rd),
        .operand_a     (operand_a),
        .operand_b     (operand_b),
        .md_ctrl_mult  (md_ctrl_mult),
        .md_ctrl_div   (md_ctrl_div),
        .md_operand_a  (md_operand_a),
        .md_operand_b  (md_operand_b),
        .md_result_rdy (md_result_rdy),
        .md_result     (md_result),
        .md_exception  (md_exception),
        .stall         (stall),
        .wb_we         (wb_we),
        .wb_rd         (wb_rd),
        .wb_data       (wb_data),
        .busy          (busy)
    );

    always #5 clock = ~clock;

    // One MUL/DIV transaction and the writeback it must produce.
    // delay = WAIT cycles until the unit answers (1 = first WAIT cycle), 0 = never.
    typedef struct {
        bit          is_div;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        int          delay;
        bit          uexc;
        bit          exp_we;
        logic [4:0]  exp_rd;
        logic [31:0] exp_data;
        int          exp_wbc;
    } txn_t;

    // Reference: what the writeback should be, from the architectural rules
    function automatic txn_t model(input txn_t t);
        txn_t        r;
        bit          timed_out;
        bit          exc;
        logic [31:0] res;
        r = t;
        timed_out = (t.delay == 0) || (t.delay > TO);
        exc = timed_out || t.uexc;
        res = t.is_div ? ((t.b == 32'd0) ? 32'd0 : t.a / t.b) : t.a * t.b;
        r.exp_wbc  = 2 + (timed_out ? TO : t.delay);
        r.exp_we   = exc || (t.rd != 5'd0);
        r.exp_rd   = exc ? 5'd30 : t.rd;
        r.exp_data = exc ? (t.is_div ? 32'd5 : 32'd4) : res;
        return r;
    endfunction

    task automatic check_obs(input logic [41:0] exp, input string name, input int c);
        logic [41:0] got;
        got = {stall, busy, md_ctrl_mult, md_ctrl_div, wb_we, wb_rd, wb_data};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got stall/busy/mult/div/we=%b%b%b%b%b rd=%0d data=%h required stall/busy/mult/div/we=%b%b%b%b%b rd=%0d data=%h",
                     name, c, got[41], got[40], got[39], got[38], got[37], got[36:32], got[31:0],
                     exp[41], exp[40], exp[39], exp[38], exp[37], exp[36:32], exp[31:0]);
        end
    endtask

    task automatic check_val(input logic [31:0] got, input logic [31:0] exp, input string name, input int c);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got %h required %h", name, c, got, exp);
        end
    endtask

    // IDLE cycle with no request: everything quiet
    task automatic idle_cycle(input string name, input int c);
        issue_valid   = 1'b0;
        md_result_rdy = 1'b0;
        operand_a     = $urandom;
        operand_b     = $urandom;
        issue_rd      = 5'($urandom);
        @(negedge clock);
        check_obs(42'd0, name, c);
        @(posedge clock);
        #1;
    endtask

    // Drive one transaction cycle by cycle, acting as the mult/div unit.
    // abort_c >= 0 pulls reset low in that cycle and ends the transaction.
    task automatic run_txn(input txn_t t, input string name, input int abort_c);
        logic [31:0] res;
        logic [41:0] exp;
        int          rdy_c;
        res   = t.uexc ? 32'hDEAD_BEEF : (t.is_div ? t.a / t.b : t.a * t.b);
        rdy_c = (t.delay > 0) ? 1 + t.delay : -1;
        for (int c = 0; c <= t.exp_wbc; c++) begin
            if (c == abort_c) begin
                reset         = 1'b0;
                issue_valid   = 1'b1;
                md_result_rdy = 1'b1;
                #1;
                check_obs(42'd0, {name, "_in_reset"}, c);
                check_val(md_operand_a, 32'd0, {name, "_rst_opa"}, c);
                @(posedge clock);
                #1;
                reset = 1'b1;
                return;
            end
            // the request is only meaningful in cycle 0; WB sees a spurious one that must be ignored
            issue_valid   = (c == 0) || (c == t.exp_wbc);
            issue_is_div  = (c == 0) ? t.is_div : ~t.is_div;
            issue_rd      = (c == 0) ? t.rd : 5'($urandom);
            operand_a     = (c == 0) ? t.a : $urandom;
            operand_b     = (c == 0) ? t.b : $urandom;
            // a stray ready during the start-pulse cycle must be ignored
            md_result_rdy = (c == 1) || (c == rdy_c);
            md_result     = (c == rdy_c) ? res : $urandom;
            md_exception  = (c == rdy_c) ? t.uexc : (c == 1);
            @(negedge clock);
            exp = {(c < t.exp_wbc), (c != 0), (c == 1) && !t.is_div, (c == 1) && t.is_div,
                   (c == t.exp_wbc) ? t.exp_we : 1'b0,
                   (c == t.exp_wbc) ? t.exp_rd : 5'd0,
                   (c == t.exp_wbc) ? t.exp_data : 32'd0};
            check_obs(exp, name, c);
            if (c >= 1 && c < t.exp_wbc) begin
                check_val(md_operand_a, t.a, {name, "_opa"}, c);
                check_val(md_operand_b, t.b, {name, "_opb"}, c);
            end
            @(posedge clock);
            #1;
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        txn_t dir [8];
        txn_t t;

        // is_div, a, b, rd, delay, uexc, exp_we, exp_rd, exp_data, exp_wbc
        dir[0] = '{1'b0, 32'd7,       32'd6,       5'd3, 1,  1'b0, 1'b1, 5'd3,  32'd42, 3};
        dir[1] = '{1'b1, 32'd10,      32'd0,       5'd5, 32, 1'b1, 1'b1, 5'd30, 32'd5,  34};
        dir[2] = '{1'b0, 32'd3,       32'd5,       5'd0, 2,  1'b0, 1'b0, 5'd0,  32'd15, 4};
        dir[3] = '{1'b1, 32'd9,       32'd3,       5'd8, 0,  1'b0, 1'b1, 5'd30, 32'd5,  66};
        dir[4] = '{1'b1, 32'd20,      32'd4,       5'd6, 64, 1'b0, 1'b1, 5'd6,  32'd5,  66};
        dir[5] = '{1'b0, 32'h0001_0000, 32'h0001_0000, 5'd7, 2, 1'b1, 1'b1, 5'd30, 32'd4, 4};
        dir[6] = '{1'b0, 32'd5,       32'd9,       5'd4, 65, 1'b0, 1'b1, 5'd30, 32'd4,  66};
        dir[7] = '{1'b1, 32'd100,     32'd7,       5'd9, 3,  1'b0, 1'b1, 5'd9,  32'd14, 5};

        // Reset state, with a request present: stall must still be 0
        issue_valid = 1'b1;
        #3;
        check_obs(42'd0, "reset_outputs", 0);
        check_val(md_operand_a, 32'd0, "reset_opa", 0);
        check_val(md_operand_b, 32'd0, "reset_opb", 0);
        issue_valid = 1'b0;
        @(posedge clock);
        #1;
        reset = 1'b1;
        idle_cycle("idle_after_reset", 0);

        // Directed table
        for (int i = 0; i < 8; i++) begin
            run_txn(dir[i], $sformatf("dir%0d", i), -1);
            idle_cycle($sformatf("dir%0d_idle", i), 0);
        end

        // Back-to-back MUL rd=1 then DIV rd=2, both answered after 3 cycles
        t = '{1'b0, 32'd11, 32'd13, 5'd1, 3, 1'b0, 1'b0, 5'd0, 32'd0, 0};
        run_txn(model(t), "b2b_mul", -1);
        t = '{1'b1, 32'd1000, 32'd8, 5'd2, 3, 1'b0, 1'b0, 5'd0, 32'd0, 0};
        run_txn(model(t), "b2b_div", -1);
        idle_cycle("b2b_idle", 0);

        // Reset for one cycle in the middle of WAIT, then silence, then a fresh op
        t = '{1'b1, 32'd50, 32'd5, 5'd11, 0, 1'b0, 1'b0, 5'd0, 32'd0, 0};
        run_txn(model(t), "rst_mid_wait", 10);
        for (int c = 0; c < 70; c++) begin
            idle_cycle("after_rst_quiet", c);
        end
        t = '{1'b0, 32'd12, 32'd12, 5'd12, 2, 1'b0, 1'b0, 5'd0, 32'd0, 0};
        run_txn(model(t), "after_rst_fresh", -1);
        idle_cycle("after_rst_idle", 0);

        // Randomized transactions, sometimes back-to-back
        for (int i = 0; i < 24; i++) begin
            t.is_div = 1'($urandom_range(0, 1));
            t.a      = $urandom;
            t.b      = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 2)) : $urandom;
            t.rd     = 5'($urandom);
            t.delay  = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 6));
            t.uexc   = ($urandom_range(0, 7) == 0) || (t.is_div && t.b == 32'd0);
            t = model(t);
            run_txn(t, $sformatf("rnd%0d", i), -1);
            if ($urandom_range(0, 1) == 0) begin
                idle_cycle($sformatf("rnd%0d_idle", i), 0);
            end
        end
        idle_cycle("final_idle", 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/multdiv_sequencer.md
Name: multdiv_sequencer

Overview:
- Multi-cycle sequencer that lets the single-cycle datapath share the iterative mult/div unit.
- On a decoded R-type MUL or DIV, it freezes PC/IR and latches the operands. It then pulses the unit's start control and waits for result-ready, with a watchdog.
- Finally it drives one register-file writeback, either the result to rd or the exception code to $rstatus.
- Sits between the instruction decoder/regfile read ports and the mult/div unit; its stall output gates the PC register enable.

Parameters:
- DATA_WIDTH, 32, operand/result width.
- TIMEOUT, 64, maximum WAIT cycles before a forced exception; must be >= 2.
- RSTATUS_REG, 30, register index written on exception.
- MUL_EXC_CODE, 4, value written to $rstatus on multiply exception or timeout.
- DIV_EXC_CODE, 5, value written to $rstatus on divide exception or timeout.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- issue_valid  in  1  decoder flags current instruction as R-type MUL (ALUop 00110) or DIV (ALUop 00111).
- issue_is_div  in  1  1 = DIV, 0 = MUL; valid with issue_valid.
- issue_rd  in  5  destination register.
- operand_a  in  DATA_WIDTH  regfile read A.
- operand_b  in  DATA_WIDTH  regfile read B.
- md_ctrl_mult  out  1  one-cycle start pulse, multiply.
- md_ctrl_div  out  1  one-cycle start pulse, divide.
- md_operand_a  out  DATA_WIDTH  latched operand A; stable from ISSUE through WAIT.
- md_operand_b  out  DATA_WIDTH  latched operand B; stable from ISSUE through WAIT.
- md_result_rdy  in  1  unit result valid.
- md_result  in  DATA_WIDTH  unit result.
- md_exception  in  1  unit exception (overflow or divide-by-zero); valid with md_result_rdy.
- stall  out  1  1 = hold PC/IR, and suppress the datapath's normal regfile write.
- wb_we  out  1  writeback enable, one cycle.
- wb_rd  out  5  writeback register.
- wb_data  out  DATA_WIDTH  writeback value.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- FSM states: IDLE, ISSUE, WAIT, WB. Encoding is defined in the package.
- Reset (reset=0, asynchronous):
  - State goes to IDLE; counter, latched operands, rd, op and captured result/exception all clear to 0.
  - Every output is 0.
  - Reset mid-operation discards any pending writeback, and no wb_we is produced.
- IDLE:
  - stall = issue_valid (combinational), so the PC does not advance past the MUL/DIV.
  - If issue_valid, latch operand_a, operand_b, issue_rd and issue_is_div, then go to ISSUE.
- ISSUE (1 cycle):
  - stall=1.
  - md_ctrl_div=issue_is_div latched value; md_ctrl_mult is its complement. Exactly one of them is high, for exactly this cycle.
  - Clear the counter and go to WAIT.
  - md_result_rdy is ignored in this state.
- WAIT:
  - stall=1; the counter increments each cycle.
  - md_result_rdy=1: capture md_result and md_exception, go to WB.
  - Else if counter == TIMEOUT-1: force exception=1 and result=0, go to WB.
  - If rdy arrives in the timeout cycle, rdy wins.
- WB (1 cycle):
  - stall=0, so the PC advances on the closing edge.
  - No exception: wb_we=1, wb_rd=latched rd, wb_data=result. If rd==0, wb_we=0.
  - Exception: wb_we=1, wb_rd=RSTATUS_REG, wb_data=MUL_EXC_CODE or DIV_EXC_CODE, zero-extended to DATA_WIDTH.
  - issue_valid is ignored; go to IDLE.
- Minimum latency: issue seen in cycle 0, pulse in cycle 1, rdy earliest in cycle 2, writeback in cycle 3. stall is high in cycles 0-2.
- Back-to-back MUL/DIV: the second one is accepted in the IDLE cycle after WB, so there is no bubble beyond the FSM.
- Outside WB, wb_rd and wb_data are 0.
- Counter width is clog2(TIMEOUT+1); it never wraps because it exits at TIMEOUT-1.

Decomposition:
- Shared package (processor_pkg) holds:
  - FSM state encoding;
  - ALUop constants MUL=00110 and DIV=00111;
  - RSTATUS index 30;
  - exception codes (add 1, addi 2, sub 3, mul 4, div 5).
- One sub-module, md_timeout_counter: synchronous clear, enable, and a terminal-count output at TIMEOUT-1, with asynchronous active-low reset.

Test Plan:
- MUL 7*6, rd=3, unit rdy 1 cycle after pulse:
  - md_ctrl_mult high exactly in cycle 1; stall high in cycles 0-2.
  - Cycle 3: wb_we=1, wb_rd=3, wb_data=42, stall=0.
- DIV 10/0, rd=5, unit returns rdy with exception=1 after 32 cycles: wb_rd=30, wb_data=5, no write to r5.
- MUL with rd=0 and no exception: wb_we stays 0 throughout; the FSM still returns to IDLE after WB.
- DIV where the unit never asserts rdy (TIMEOUT=64): exactly 64 WAIT cycles, then WB with wb_rd=30, wb_data=5.
- reset pulled low for 1 cycle in the middle of WAIT: all outputs 0 immediately; no wb_we afterwards; the next issue_valid starts a fresh ISSUE.
- Back-to-back MUL (rd=1) then DIV (rd=2), both rdy after 3 cycles:
  - Two separate writebacks to r1 and r2.
  - md_ctrl_mult and md_ctrl_div each pulse exactly once.
  - md_operand_a/b hold stable while each unit is working.
